// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types for the cache fill arbiter: controller states and the fixed
// requester slot assignments seen by the caches.
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  // Lower index wins arbitration, so the D-cache sits in slot 0.
  localparam int REQ_DCACHE = 0;
  localparam int REQ_ICACHE = 1;

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag;
// used to track both issued reads and returned words of a block fill.
module fill_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Main-memory front end: arbitrates cache block fills and write-through stores
// onto one pipelined memory port, streaming returned words into the cache.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4,
  parameter int NUM_REQ     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          miss_req,
  input  logic [NUM_REQ*ADDR_W-1:0]   miss_addr,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  output logic [NUM_REQ-1:0]          fill_we,
  output logic [ADDR_W-1:0]           fill_addr,
  output logic [DATA_W-1:0]           fill_data,
  output logic [NUM_REQ-1:0]          fill_done,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out,
  input  logic                        mem_data_valid
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

  state_t              state;
  logic [NUM_REQ-1:0]  grant;
  logic [ADDR_W-1:0]   base;
  logic [NUM_REQ-1:0]  lowest_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    ret_cnt;
  logic                issue_tc;
  logic                ret_tc;
  logic                in_fill;
  logic                issuing;
  logic                ret_strobe;
  logic                cnt_clr;

  // Two's-complement trick isolates the lowest asserted request bit.
  assign lowest_req = miss_req & (~miss_req + NUM_REQ'(1));

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lowest_req[i]) begin
        sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stores are checked first so a following miss reads the stored value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      base  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_req) begin
            state <= ST_WRITE;
          end else if (|miss_req) begin
            state <= ST_FILL;
            grant <= lowest_req;
            base  <= sel_addr & ~BLOCK_MASK;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_FILL: begin
          if (ret_strobe && ret_tc) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_fill    = (state == ST_FILL);
  assign cnt_clr    = !in_fill;
  assign issuing    = in_fill && !issue_tc;
  assign ret_strobe = in_fill && mem_data_valid;

  fill_counter #(.WIDTH(CNT_W), .TERMINAL(BLOCK_WORDS)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issuing),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  fill_counter #(.WIDTH(CNT_W), .TERMINAL(BLOCK_WORDS - 1)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (ret_strobe),
    .count (ret_cnt),
    .tc    (ret_tc)
  );

  assign wr_ack      = (state == ST_WRITE);
  assign mem_en      = wr_ack || issuing;
  assign mem_wr      = wr_ack;
  assign mem_addr    = wr_ack  ? wr_addr :
                       issuing ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
  assign mem_data_in = wr_ack ? wr_data : '0;

  assign fill_we   = ret_strobe ? grant : '0;
  assign fill_done = (ret_strobe && ret_tc) ? grant : '0;
  assign fill_addr = ret_strobe ? base + ADDR_W'({ret_cnt, 1'b0}) : '0;
  assign fill_data = ret_strobe ? mem_data_out : '0;

endmodule
